pc_ras: RTL and testbench

Parametrised program-counter unit with conditional relative branches, absolute jumps, and a call/return stack. The program counter output addresses instruction memory. The block sits between the decoder/ALU flag outputs and the instruction fetch stage. It adds four things to a plain PC: configurable widths, a fetch-stall enable, a HALT state, and a circular return-address stack (RAS) with sticky overflow/underflow flags.

---
 rtl/pc_ras_if.sv | 33 +++
 rtl/pc_ras.sv | 153 +++++++++++++++
 tb/tb_pc_ras.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_ras_if.sv
// pc_ras_if: control/flag inputs and PC/stack status outputs of pc_ras.
// master drives decode inputs, slave is the PC unit.
interface pc_ras_if #(
    parameter int PC_W      = 8,
    parameter int OFF_W     = 15,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic             en;
    logic [2:0]       ctl;
    logic [2:0]       cond;
    logic             z;
    logic             lt;
    logic [OFF_W-1:0] offset;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  PC;
    logic             taken;
    logic             halted;
    logic [CW-1:0]    ras_cnt;
    logic             ras_ovf;
    logic             ras_unf;

    modport master (
        output en, ctl, cond, z, lt, offset, target,
        input  PC, taken, halted, ras_cnt, ras_ovf, ras_unf
    );

    modport slave (
        input  en, ctl, cond, z, lt, offset, target,
        output PC, taken, halted, ras_cnt, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: program counter with relative branch, absolute jump,
// circular return-address stack and HALT state.
module pc_ras #(
    parameter int          PC_W       = 8,
    parameter int          OFF_W      = 15,
    parameter int          RAS_DEPTH  = 4,
    parameter int unsigned START_ADDR = 0
) (
    input logic       clk,
    input logic       reset,
    pc_ras_if.slave   bus
);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int SW = $clog2(RAS_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t          state;
    state_t          state_nxt;

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] top;
    logic [PC_W-1:0] stk [RAS_DEPTH];
    logic [SW-1:0]   sp;
    logic [SW-1:0]   sp_inc;
    logic [SW-1:0]   sp_dec;
    logic [CW-1:0]   cnt;
    logic            ovf;
    logic            unf;

    logic            is_seq;
    logic            is_brel;
    logic            is_jabs;
    logic            is_call;
    logic            is_ret;
    logic            is_halt;
    logic            cond_ok;
    logic            full;
    logic            empty;
    logic            go;

    assign is_brel = (bus.ctl == 3'b001);
    assign is_jabs = (bus.ctl == 3'b010);
    assign is_call = (bus.ctl == 3'b011);
    assign is_ret  = (bus.ctl == 3'b100);
    assign is_halt = (bus.ctl == 3'b101);
    assign is_seq  = ~(is_brel | is_jabs | is_call
                     | is_ret | is_halt);

    always_comb begin
        cond_ok = 1'b0;
        unique case (bus.cond)
            3'b000:  cond_ok = 1'b1;
            3'b001:  cond_ok = bus.z;
            3'b010:  cond_ok = ~bus.z;
            3'b011:  cond_ok = bus.lt;
            3'b100:  cond_ok = ~bus.lt;
            default: cond_ok = 1'b0;
        endcase
    end

    assign go     = (state == RUN) && bus.en;
    assign full   = (cnt == CW'(RAS_DEPTH));
    assign empty  = (cnt == '0);
    assign pc_inc = pc + 1'b1;
    // signed cast sign-extends or truncates the offset to PC width
    assign br_tgt = pc + PC_W'($signed(bus.offset));

    // sp is the next write slot; when full it also marks the oldest
    assign sp_inc = (sp == SW'(RAS_DEPTH - 1)) ? '0 : sp + 1'b1;
    assign sp_dec = (sp == '0) ? SW'(RAS_DEPTH - 1) : sp - 1'b1;
    assign top    = stk[sp_dec];

    assign bus.taken = go & ((is_brel & cond_ok) | is_jabs
                     | is_call | (is_ret & ~empty));

    always_comb begin
        pc_nxt = pc;
        if (go) begin
            unique case (1'b1)
                is_seq:  pc_nxt = pc_inc;
                is_brel: pc_nxt = cond_ok ? br_tgt : pc_inc;
                is_jabs: pc_nxt = bus.target;
                is_call: pc_nxt = bus.target;
                is_ret:  pc_nxt = empty ? pc_inc : top;
                is_halt: pc_nxt = pc;
                default: pc_nxt = pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == RUN && bus.en && is_halt) begin
            state_nxt = HALT;
        end
    end

    always_comb begin
        bus.halted = (state == HALT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= PC_W'(START_ADDR);
            sp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            pc <= pc_nxt;
            if (go && is_call) begin
                sp <= sp_inc;
                if (full) begin
                    ovf <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (go && is_ret) begin
                if (empty) begin
                    unf <= 1'b1;
                end else begin
                    sp  <= sp_dec;
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    // stack storage needs no reset; cnt defines which entries are valid
    always_ff @(posedge clk) begin
        if (!reset && go && is_call) begin
            stk[sp] <= pc_inc;
        end
    end

    assign bus.PC      = pc;
    assign bus.ras_cnt = cnt;
    assign bus.ras_ovf = ovf;
    assign bus.ras_unf = unf;
endmodule

// File: tb/tb_pc_ras.sv
// tb_pc_ras: directed and randomized checks of pc_ras against a
// queue-based behavioural model.
module tb_pc_ras;
    localparam int PC_W  = 8;
    localparam int OFF_W = 15;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << PC_W) - 1;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    int   m_pc;
    bit   m_halt;
    bit   m_ovf;
    bit   m_unf;
    int   m_ras[$];

    pc_ras_if #(.PC_W(PC_W), .OFF_W(OFF_W), .RAS_DEPTH(DEPTH)) bus ();

    pc_ras #(
        .PC_W(PC_W), .OFF_W(OFF_W),
        .RAS_DEPTH(DEPTH), .START_ADDR(0)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit cond_true(input logic [2:0] cd,
                                     input bit zz, input bit ll);
        case (cd)
            3'd0:    return 1'b1;
            3'd1:    return zz;
            3'd2:    return !zz;
            3'd3:    return ll;
            3'd4:    return !ll;
            default: return 1'b0;
        endcase
    endfunction

    // one clock: drive, sample taken, clock, advance the model
    task automatic step(input bit r, input bit e, input logic [2:0] c,
                        input logic [2:0] cd, input bit zz, input bit ll,
                        input logic [OFF_W-1:0] off,
                        input logic [PC_W-1:0] tgt,
                        output bit tk_obs, output bit tk_exp);
        int soff;
        reset = r; bus.en = e; bus.ctl = c; bus.cond = cd;
        bus.z = zz; bus.lt = ll; bus.offset = off; bus.target = tgt;
        #1;
        tk_obs = bus.taken;
        tk_exp = !m_halt && e &&
                 ((c == 3'd1 && cond_true(cd, zz, ll)) || c == 3'd2 ||
                  c == 3'd3 || (c == 3'd4 && m_ras.size() > 0));
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
            m_ras.delete();
        end else if (!m_halt && e) begin
            case (c)
                3'd1: begin
                    soff = int'($signed(off));
                    m_pc = cond_true(cd, zz, ll) ?
                           (m_pc + soff) & MASK : (m_pc + 1) & MASK;
                end
                3'd2: m_pc = int'(tgt);
                3'd3: begin
                    m_ras.push_back((m_pc + 1) & MASK);
                    if (m_ras.size() > DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1;
                    end
                    m_pc = int'(tgt);
                end
                3'd4: begin
                    if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                    else begin
                        m_pc = (m_pc + 1) & MASK;
                        m_unf = 1;
                    end
                end
                3'd5: m_halt = 1;
                default: m_pc = (m_pc + 1) & MASK;
            endcase
        end
    endtask

    task automatic op(input logic [2:0] c, input logic [PC_W-1:0] tgt,
                      output bit tk_obs, output bit tk_exp);
        step(0, 1, c, 3'd0, 0, 0, '0, tgt, tk_obs, tk_exp);
    endtask

    task automatic do_reset();
        bit a, b;
        step(1, 1, 3'd2, 3'd0, 0, 0, '0, 8'hAA, a, b);
        step(1, 0, 3'd3, 3'd0, 0, 0, '0, 8'h55, a, b);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.PC !== 8'd0) begin
            failures++; $display("FAIL reset_pc got=%0d want=0", bus.PC);
        end
        checks++;
        if (bus.halted !== 1'b0) begin
            failures++; $display("FAIL reset_halted got=%0b want=0", bus.halted);
        end
        checks++;
        if (bus.ras_cnt !== 3'd0) begin
            failures++; $display("FAIL reset_cnt got=%0d want=0", bus.ras_cnt);
        end
        checks++;
        if (bus.ras_ovf !== 1'b0 || bus.ras_unf !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=%0b%0b want=00", bus.ras_ovf, bus.ras_unf);
        end
    endtask

    task automatic test_wrap();
        bit to, te;
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            op(3'd0, '0, to, te);
            if (bus.PC !== m_pc[PC_W-1:0] || to !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL seq_walk got=%0d bad cycles want=0", bad);
        end
        checks++;
        if (bus.PC !== 8'd0) begin
            failures++; $display("FAIL seq_wrap got=%0d want=0", bus.PC);
        end
        checks++;
        if (bus.ras_ovf !== 1'b0 || bus.ras_unf !== 1'b0) begin
            failures++; $display("FAIL wrap_flags got=%0b%0b want=00", bus.ras_ovf, bus.ras_unf);
        end
    endtask

    task automatic test_brel();
        bit to, te;
        op(3'd2, 8'd10, to, te);
        step(0, 1, 3'd1, 3'd1, 1, 0, 15'h7FFD, '0, to, te);
        checks++;
        if (bus.PC !== 8'd7 || to !== 1'b1) begin
            failures++; $display("FAIL brel_taken got pc=%0d tk=%0b want pc=7 tk=1", bus.PC, to);
        end
        op(3'd2, 8'd10, to, te);
        step(0, 1, 3'd1, 3'd1, 0, 0, 15'h7FFD, '0, to, te);
        checks++;
        if (bus.PC !== 8'd11 || to !== 1'b0) begin
            failures++; $display("FAIL brel_not got pc=%0d tk=%0b want pc=11 tk=0", bus.PC, to);
        end
        step(0, 1, 3'd1, 3'd7, 1, 1, 15'h0010, '0, to, te);
        checks++;
        if (bus.PC !== 8'd12 || to !== 1'b0) begin
            failures++; $display("FAIL brel_never got pc=%0d tk=%0b want pc=12 tk=0", bus.PC, to);
        end
        step(0, 1, 3'd1, 3'd4, 0, 0, 15'h0020, '0, to, te);
        checks++;
        if (bus.PC !== 8'd44 || to !== 1'b1) begin
            failures++; $display("FAIL brel_fwd got pc=%0d tk=%0b want pc=44 tk=1", bus.PC, to);
        end
    endtask

    task automatic test_call_ret();
        bit to, te;
        logic [2:0]      ops [4];
        logic [PC_W-1:0] tg  [4];
        logic [PC_W-1:0] pcx [4];
        logic [2:0]      cnx [4];
        ops = '{3'd3, 3'd3, 3'd4, 3'd4};
        tg  = '{8'd40, 8'd80, 8'd0, 8'd0};
        pcx = '{8'd40, 8'd80, 8'd41, 8'd6};
        cnx = '{3'd1, 3'd2, 3'd1, 3'd0};
        do_reset();
        op(3'd2, 8'd5, to, te);
        for (int i = 0; i < 4; i++) begin
            op(ops[i], tg[i], to, te);
            checks++;
            if (bus.PC !== pcx[i] || bus.ras_cnt !== cnx[i] || to !== 1'b1) begin
                failures++;
                $display("FAIL nest_%0d got pc=%0d cnt=%0d tk=%0b want pc=%0d cnt=%0d tk=1",
                         i, bus.PC, bus.ras_cnt, to, pcx[i], cnx[i]);
            end
        end
    endtask

    task automatic test_overflow();
        bit to, te;
        logic [PC_W-1:0] rx [4];
        rx = '{8'd131, 8'd121, 8'd111, 8'd101};
        do_reset();
        op(3'd2, 8'd50, to, te);
        for (int i = 0; i < 5; i++) op(3'd3, PC_W'(100 + 10 * i), to, te);
        checks++;
        if (bus.ras_cnt !== 3'd4 || bus.ras_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf got cnt=%0d ovf=%0b want cnt=4 ovf=1", bus.ras_cnt, bus.ras_ovf);
        end
        for (int i = 0; i < 4; i++) begin
            op(3'd4, '0, to, te);
            checks++;
            if (bus.PC !== rx[i]) begin
                failures++; $display("FAIL ovf_ret_%0d got=%0d want=%0d", i, bus.PC, rx[i]);
            end
        end
        checks++;
        if (bus.ras_cnt !== 3'd0 || bus.ras_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drain got cnt=%0d ovf=%0b want cnt=0 ovf=1", bus.ras_cnt, bus.ras_ovf);
        end
    endtask

    task automatic test_underflow();
        bit to, te;
        do_reset();
        op(3'd2, 8'd20, to, te);
        op(3'd4, '0, to, te);
        checks++;
        if (bus.PC !== 8'd21 || bus.ras_unf !== 1'b1 || to !== 1'b0) begin
            failures++;
            $display("FAIL unf got pc=%0d unf=%0b tk=%0b want pc=21 unf=1 tk=0", bus.PC, bus.ras_unf, to);
        end
        for (int i = 0; i < 3; i++) op(3'd0, '0, to, te);
        checks++;
        if (bus.PC !== 8'd24 || bus.ras_unf !== 1'b1 || bus.ras_cnt !== 3'd0) begin
            failures++;
            $display("FAIL unf_sticky got pc=%0d unf=%0b cnt=%0d want pc=24 unf=1 cnt=0",
                     bus.PC, bus.ras_unf, bus.ras_cnt);
        end
    endtask

    task automatic test_stall_halt();
        bit to, te;
        int bad;
        op(3'd2, 8'd25, to, te);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 3'd2, 3'd0, 0, 0, '0, 8'd99, to, te);
            if (bus.PC !== 8'd25 || to !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL stall got=%0d bad cycles want=0", bad);
        end
        op(3'd2, 8'd30, to, te);
        op(3'd5, 8'd77, to, te);
        checks++;
        if (bus.PC !== 8'd30 || bus.halted !== 1'b1 || to !== 1'b0) begin
            failures++;
            $display("FAIL halt got pc=%0d h=%0b tk=%0b want pc=30 h=1 tk=0", bus.PC, bus.halted, to);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)),
                 3'd0, 1, 1, 15'h0005, 8'd200, to, te);
            if (bus.PC !== 8'd30 || bus.halted !== 1'b1 || to !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL halt_hold got=%0d bad cycles want=0", bad);
        end
        step(1, 0, 3'd2, 3'd0, 0, 0, '0, 8'd99, to, te);
        checks++;
        if (bus.PC !== 8'd0 || bus.halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_reset got pc=%0d h=%0b want pc=0 h=0", bus.PC, bus.halted);
        end
    endtask

    task automatic test_back_to_back();
        bit to, te;
        do_reset();
        op(3'd2, 8'd60, to, te);
        op(3'd3, 8'd60, to, te);
        checks++;
        if (bus.PC !== 8'd60 || bus.ras_cnt !== 3'd1 || to !== 1'b1) begin
            failures++;
            $display("FAIL call_self got pc=%0d cnt=%0d tk=%0b want pc=60 cnt=1 tk=1",
                     bus.PC, bus.ras_cnt, to);
        end
        op(3'd4, '0, to, te);
        checks++;
        if (bus.PC !== 8'd61 || bus.ras_cnt !== 3'd0) begin
            failures++; $display("FAIL b2b_ret1 got pc=%0d cnt=%0d want pc=61 cnt=0", bus.PC, bus.ras_cnt);
        end
        op(3'd3, 8'd90, to, te);
        op(3'd4, '0, to, te);
        checks++;
        if (bus.PC !== 8'd62 || to !== 1'b1) begin
            failures++; $display("FAIL b2b_ret2 got pc=%0d tk=%0b want pc=62 tk=1", bus.PC, to);
        end
    endtask

    task automatic test_random();
        bit to, te, r, e;
        logic [2:0] c;
        int bad_pc, bad_st, bad_tk;
        bad_pc = 0; bad_st = 0; bad_tk = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 7) != 0);
            c = 3'($urandom_range(0, 7));
            if (c == 3'd5 && $urandom_range(0, 9) != 0) c = 3'd3;
            step(r, e, c, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 15'($urandom), 8'($urandom), to, te);
            if (!r && to !== te) bad_tk++;
            if (bus.PC !== m_pc[PC_W-1:0]) bad_pc++;
            if (bus.ras_cnt !== 3'(m_ras.size()) || bus.ras_ovf !== m_ovf ||
                bus.ras_unf !== m_unf || bus.halted !== m_halt) bad_st++;
        end
        checks++;
        if (bad_pc != 0) begin
            failures++; $display("FAIL rand_pc got=%0d bad cycles want=0", bad_pc);
        end
        checks++;
        if (bad_st != 0) begin
            failures++; $display("FAIL rand_state got=%0d bad cycles want=0", bad_st);
        end
        checks++;
        if (bad_tk != 0) begin
            failures++; $display("FAIL rand_taken got=%0d bad cycles want=0", bad_tk);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        m_pc = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
        reset = 1'b1; bus.en = 1'b0; bus.ctl = '0; bus.cond = '0;
        bus.z = 1'b0; bus.lt = 1'b0; bus.offset = '0; bus.target = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_wrap();
        test_brel();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_stall_halt();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
